// File: rtl/binary_game_core.sv
// Binary-number guessing game core: state machine, per-level countdown timer,
// LFSR target generator and guess comparator in one clocked block.
module binary_game_core #(
  parameter int WIDTH    = 4,
  parameter int LEVELS   = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int T_START  = 20,
  parameter int T_STEP   = 2,
  parameter int T_MIN    = 4,
  parameter int LIVES    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             guess_i,
  input  logic [WIDTH-1:0] switch_i,
  output logic [1:0]       state_o,
  output logic [WIDTH-1:0] target_o,
  output logic [4:0]       timeleft_o,
  output logic [7:0]       level_o,
  output logic [7:0]       score_o,
  output logic [2:0]       lives_o,
  output logic             round_p_o
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10,
    S_LOSE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [PW-1:0]    pres_q, pres_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [4:0]       timeleft_q, timeleft_d;
  logic [7:0]       level_q, level_d;
  logic [7:0]       score_q, score_d;
  logic [2:0]       lives_q, lives_d;
  logic             round_p_q, round_p_d;
  logic             tick;
  logic             new_round;

  // Time limit for a level; the subtraction is compared before it is done so
  // deep levels clamp at T_MIN instead of wrapping.
  function automatic logic [4:0] t_limit(input logic [7:0] lvl);
    int dec;
    int lim;
    dec = (int'(lvl) - 1) * T_STEP;
    if (dec >= T_START - T_MIN) lim = T_MIN;
    else                        lim = T_START - dec;
    return lim[4:0];
  endfunction

  assign tick = (state_q == S_PLAY) && (pres_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    pres_d     = '0;
    target_d   = target_q;
    timeleft_d = timeleft_q;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    round_p_d  = 1'b0;
    new_round  = 1'b0;

    case (state_q)
      S_PLAY: begin
        pres_d = tick ? '0 : pres_q + PW'(1);
        // A guess takes priority; a tick landing on the same cycle is dropped.
        if (guess_i) begin
          if (switch_i == target_q) begin
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            if (level_q == 8'(LEVELS)) begin
              state_d = S_WIN;
            end else begin
              level_d    = level_q + 8'd1;
              timeleft_d = t_limit(level_q + 8'd1);
              new_round  = 1'b1;
            end
          end else begin
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) state_d = S_LOSE;
          end
        end else if (tick) begin
          if (timeleft_q <= 5'd1) begin
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_d    = S_LOSE;
              timeleft_d = 5'd0;
            end else begin
              timeleft_d = t_limit(level_q);
              new_round  = 1'b1;
            end
          end else begin
            timeleft_d = timeleft_q - 5'd1;
          end
        end
      end
      default: begin
        if (start_i) begin
          state_d    = S_PLAY;
          level_d    = 8'd1;
          score_d    = 8'd0;
          lives_d    = 3'(LIVES);
          timeleft_d = t_limit(8'd1);
          new_round  = 1'b1;
        end
      end
    endcase

    if (new_round) begin
      target_d  = lfsr_q[WIDTH-1:0];
      pres_d    = '0;
      round_p_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 16'hACE1;
      pres_q     <= '0;
      target_q   <= '0;
      timeleft_q <= '0;
      level_q    <= '0;
      score_q    <= '0;
      lives_q    <= '0;
      round_p_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      pres_q     <= pres_d;
      target_q   <= target_d;
      timeleft_q <= timeleft_d;
      level_q    <= level_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      round_p_q  <= round_p_d;
    end
  end

  assign state_o    = state_q;
  assign target_o   = target_q;
  assign timeleft_o = timeleft_q;
  assign level_o    = level_q;
  assign score_o    = score_q;
  assign lives_o    = lives_q;
  assign round_p_o  = round_p_q;

endmodule

// File: tb/tb_binary_game_core.sv
// Bench for binary_game_core: directed game scenarios plus random play,
// every cycle compared against a behavioural game model.
module tb_binary_game_core;

  localparam int WIDTH    = 4;
  localparam int LEVELS   = 3;
  localparam int TICK_DIV = 4;
  localparam int T_START  = 5;
  localparam int T_STEP   = 1;
  localparam int T_MIN    = 4;
  localparam int LIVES    = 2;

  localparam int IDLE = 0, PLAY = 1, WIN = 2, LOSE = 3;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic             guess_i;
  logic [WIDTH-1:0] switch_i;
  logic [1:0]       state_o;
  logic [WIDTH-1:0] target_o;
  logic [4:0]       timeleft_o;
  logic [7:0]       level_o;
  logic [7:0]       score_o;
  logic [2:0]       lives_o;
  logic             round_p_o;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the game.
  int m_lfsr, m_state, m_target, m_time, m_level, m_score, m_lives, m_pres, m_round;
  int first_target;

  binary_game_core #(
    .WIDTH(WIDTH), .LEVELS(LEVELS), .TICK_DIV(TICK_DIV), .T_START(T_START),
    .T_STEP(T_STEP), .T_MIN(T_MIN), .LIVES(LIVES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .guess_i(guess_i),
    .switch_i(switch_i), .state_o(state_o), .target_o(target_o),
    .timeleft_o(timeleft_o), .level_o(level_o), .score_o(score_o),
    .lives_o(lives_o), .round_p_o(round_p_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int t_of(input int lvl);
    int v;
    v = T_START - (lvl - 1) * T_STEP;
    return (v < T_MIN) ? T_MIN : v;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_state = IDLE; m_target = 0; m_time = 0;
    m_level = 0; m_score = 0; m_lives = 0; m_pres = 0; m_round = 0;
  endtask

  task automatic model_step(input bit st, input bit gs, input int sw);
    int fb, nxt;
    bit tick, load;
    fb   = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    nxt  = (m_lfsr >> 1) | (fb << 15);
    load = 0;
    if (m_state != PLAY) begin
      m_pres = 0;
      if (st) begin
        m_state = PLAY; m_level = 1; m_score = 0; m_lives = LIVES;
        m_time = t_of(1); load = 1;
      end
    end else begin
      tick   = (m_pres == TICK_DIV - 1);
      m_pres = (m_pres + 1) % TICK_DIV;
      if (gs) begin
        if (sw == m_target) begin
          if (m_score < 255) m_score++;
          if (m_level == LEVELS) m_state = WIN;
          else begin m_level++; m_time = t_of(m_level); load = 1; end
        end else begin
          m_lives--;
          if (m_lives == 0) m_state = LOSE;
        end
      end else if (tick) begin
        if (m_time <= 1) begin
          m_lives--;
          if (m_lives == 0) begin m_state = LOSE; m_time = 0; end
          else begin m_time = t_of(m_level); load = 1; end
        end else begin
          m_time--;
        end
      end
    end
    if (load) begin
      m_target = m_lfsr % (1 << WIDTH);
      m_pres   = 0;
    end
    m_round = load;
    m_lfsr  = nxt;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".state"},    32'(state_o),    32'(m_state));
    check({tag, ".target"},   32'(target_o),   32'(m_target));
    check({tag, ".timeleft"}, 32'(timeleft_o), 32'(m_time));
    check({tag, ".level"},    32'(level_o),    32'(m_level));
    check({tag, ".score"},    32'(score_o),    32'(m_score));
    check({tag, ".lives"},    32'(lives_o),    32'(m_lives));
    check({tag, ".round_p"},  32'(round_p_o),  32'(m_round));
  endtask

  // Driver: present inputs for one cycle, advance model, compare after edge.
  task automatic cycle(input bit st, input bit gs, input int sw);
    start_i  = st;
    guess_i  = gs;
    switch_i = WIDTH'(sw);
    @(posedge clk);
    model_step(st, gs, sw);
    #1;
    compare_all("cyc");
    start_i = 1'b0;
    guess_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic wrong_guess();
    cycle(0, 1, (m_target + 1) % (1 << WIDTH));
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; guess_i = 1'b0; switch_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;

    // Start: first round of the game
    idle(3);
    cycle(1, 0, 0);
    check("start.state", 32'(state_o), PLAY);
    check("start.time", 32'(timeleft_o), 5);
    check("start.round_p", 32'(round_p_o), 1);
    first_target = m_target;

    // Three correct guesses to WIN
    for (int k = 0; k < 3; k++) begin
      idle(1);
      cycle(0, 1, m_target);
      if (k < 2) check("win.time", 32'(timeleft_o), 4);
    end
    check("win.state", 32'(state_o), WIN);
    check("win.score", 32'(score_o), 3);
    check("win.level", 32'(level_o), 3);
    cycle(0, 1, m_target);
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    check("win.restart", 32'(state_o), PLAY);

    // Two wrong guesses to LOSE
    wrong_guess();
    check("miss.lives", 32'(lives_o), 1);
    wrong_guess();
    check("lose.state", 32'(state_o), LOSE);
    check("lose.lives", 32'(lives_o), 0);
    idle(2);

    // Timeout after 5 ticks of 4 cycles
    cycle(1, 0, 0);
    for (int s = 0; s < 4; s++) begin
      idle(4);
      check("tmo.step", 32'(timeleft_o), 32'(4 - s));
    end
    idle(4);
    check("tmo.lives", 32'(lives_o), 1);
    check("tmo.time", 32'(timeleft_o), 5);
    check("tmo.level", 32'(level_o), 1);
    check("tmo.round_p", 32'(round_p_o), 1);

    // Correct guess coinciding with a tick
    idle(1);
    for (int b = 0; b < 2 * TICK_DIV && m_pres != TICK_DIV - 1; b++) idle(1);
    check("gtick.align", 32'(m_pres), TICK_DIV - 1);
    cycle(0, 1, m_target);
    check("gtick.level", 32'(level_o), 2);
    check("gtick.time", 32'(timeleft_o), 4);

    // Asynchronous reset mid-round at level 2
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    rst_n = 1'b1;
    idle(3);
    cycle(1, 0, 0);
    check("repro.target", 32'(target_o), 32'(first_target));

    // Random play
    for (int r = 0; r < 3000; r++) begin
      bit st, gs;
      int sw;
      st = ($urandom_range(0, 19) == 0);
      gs = ($urandom_range(0, 5) == 0);
      sw = ($urandom_range(0, 1) == 1) ? m_target : int'($urandom_range(0, (1 << WIDTH) - 1));
      cycle(st, gs, sw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/binary_game_core.md
# binary_game_core

Parametrised core of the binary-number guessing game. It combines the game state machine, the per-level countdown timer, the pseudo-random target generator and the guess comparator in one clocked block. Board-level blocks sit around it: the button debouncer drives `guess`, the switches drive `switch`, and the LCD driver consumes `state`, `target`, `timeleft`, `level`, `score` and `lives`. Compared with the fixed 4-bit game, it adds configurable number width, a per-level shrinking time limit, lives, a score and a terminal WIN state.

## Interface
- `WIDTH`, 4: width of the guessed number, legal range 1..16.
- `LEVELS`, 8: number of levels to clear for WIN, legal range 1..255.
- `TICK_DIV`, 50_000_000: clk cycles per timer tick (one second at 50 MHz), must be ≥2.
- `T_START`, 20: ticks allowed at level 1, legal range 1..31.
- `T_STEP`, 2: ticks removed per level.
- `T_MIN`, 4: floor on the time limit, must be ≤ `T_START`.
- `LIVES`, 3: misses allowed before LOSE, legal range 1..7.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; starts a new game from IDLE, WIN or LOSE.
- `guess`  in  1  one-cycle debounced pulse; submits `switch`.
- `switch`  in  WIDTH  player's number.
- `state`  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
- `target`  out  WIDTH  current number to match.
- `timeleft`  out  5  ticks remaining in the current round.
- `level`  out  8  current level, 1-based; 0 in IDLE after reset.
- `score`  out  8  correct guesses this game, saturating at 255.
- `lives`  out  3  remaining lives.
- `round_p`  out  1  one-cycle pulse whenever a new target is loaded.

## Operation
- Generator: a 16-bit Fibonacci LFSR with taps 16,14,13,11, seeded to 16'hACE1 on reset. It shifts every cycle in every state. `target` is the low WIDTH bits of the LFSR, sampled on the cycle a round is loaded; zero is a legal target.
- Limit for level L: T(L) = max(T_START − (L−1)·T_STEP, T_MIN). Compute it without underflow; saturate at T_MIN.
- Prescaler counts 0..TICK_DIV−1 in PLAY only. At wrap it emits a tick. It clears on every round load and in non-PLAY states.
- IDLE/WIN/LOSE with `start` → PLAY. Load level=1, score=0, lives=LIVES, timeleft=T(1), a new target, and pulse `round_p`. `guess` is ignored in these states.
- PLAY with `guess` and `switch`==`target` (correct):
  - score+1, saturating.
  - If level==LEVELS → WIN; the timer freezes and the outputs hold.
  - Otherwise level+1, timeleft=T(level+1), new target, `round_p`.
- PLAY with `guess` and a mismatch: lives−1.
  - If lives becomes 0 → LOSE.
  - Otherwise target and timeleft are kept and the countdown continues.
- PLAY on a tick: timeleft−1.
- PLAY, tick while timeleft==1 (timeout): treat as a miss.
  - lives−1; if lives becomes 0 → LOSE.
  - Otherwise stay at the same level with timeleft=T(level), a new target and `round_p`.
- Priority within one cycle: `start` (only outside PLAY), then `guess`, then tick. When a guess lands on a tick cycle, the tick is discarded.
- A `start` in PLAY is ignored.
- WIN/LOSE hold all outputs until `start`.

## Timing
- All outputs are registered. Every response appears on the edge after the input cycle: a `guess` in cycle n updates state/level/score/lives/target at edge n+1. `round_p` is high during cycle n+1 only.
- The first tick of a round occurs TICK_DIV cycles after the round load. A round with no guesses therefore times out TICK_DIV·T(L) cycles after loading.
- Reset values: state=IDLE, target=0, timeleft=0, level=0, score=0, lives=0, round_p=0, prescaler=0, LFSR=16'hACE1.
- Reset is asynchronous in any state, including mid-round. Outputs take their reset values immediately and no pulse is emitted. The first post-reset edge starts the LFSR sequence deterministically.
- Back-to-back `guess` pulses on consecutive cycles are each evaluated against the target that is current in that cycle.

## Test plan
Parameters for all scenarios: WIDTH=4, LEVELS=3, TICK_DIV=4, T_START=5, T_STEP=1, T_MIN=4, LIVES=2.
- Reset, then `start` → the next edge shows state=01, level=1, lives=2, score=0, timeleft=5, round_p=1, and target equal to the low 4 bits of the LFSR model.
- Three correct guesses (switch=target each time) → timeleft reloads 4 and then 4 (floored); after the third guess, state=10, score=3, level=3. A later `guess` causes no change.
- Wrong guess with a mismatched `switch` → lives=1 with target unchanged; a second wrong guess → state=11, lives=0.
- No guesses → timeleft steps 5,4,3,2,1 at 4-cycle intervals. The tick at timeleft=1 gives lives=1, timeleft=5, a new target and round_p; level stays 1.
- Correct `guess` on the same cycle as a tick → level=2 and timeleft=4, with no decrement applied.
- `rst_n` low mid-round at level 2 → all outputs at reset values asynchronously. A later `start` reproduces the same target as the first game after reset.
